// File: rtl/rr_priority_encoder.sv
// Round-robin N-to-log2(N) encoder: grants one asserted request line by rotating
// priority and holds the index under a valid/ack handshake until accepted.
module rr_priority_encoder #(
   parameter  int M = 3,
   localparam int N = 2**M
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] Req,
   input  logic         Ena,
   input  logic         Ack,
   output logic [M-1:0] Sel,
   output logic         Valid,
   output logic [N-1:0] Grant,
   output logic         Multi
);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t         state, state_nxt;
   logic [M-1:0]   ptr;
   logic [M-1:0]   off;
   logic [M-1:0]   idx;
   logic [N-1:0]   rot;
   logic           hit;
   logic           multi_nxt;
   logic           grant_ld;
   logic           rel;
   logic           adv;

   // rot[i] is the request i places after ptr; M-bit add wraps modulo N
   for (genvar g = 0; g < N; g++) begin : g_rot
      assign rot[g] = Req[ptr + M'(g)];
   end

   always_comb begin
      hit = 1'b0;
      off = '0;
      for (int i = N-1; i >= 0; i--) begin
         if (rot[i]) begin
            hit = 1'b1;
            off = M'(i);
         end
      end
   end

   assign idx       = ptr + off;
   assign multi_nxt = |(Req & (Req - N'(1)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (Ena && hit)         state_nxt = HOLD;
         HOLD: if (Ack || !Req[Sel])   state_nxt = IDLE;
         default:                      state_nxt = IDLE;
      endcase
   end

   // Ack wins over a dropped request at the same edge, so priority still rotates
   always_comb begin
      grant_ld = 1'b0;
      rel      = 1'b0;
      adv      = 1'b0;
      case (state)
         IDLE: grant_ld = Ena & hit;
         HOLD: begin
            rel = Ack | ~Req[Sel];
            adv = Ack;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Sel   <= '0;
         Valid <= 1'b0;
         Grant <= '0;
         Multi <= 1'b0;
         ptr   <= '0;
      end else if (grant_ld) begin
         Sel   <= idx;
         Valid <= 1'b1;
         Grant <= N'(1) << idx;
         Multi <= multi_nxt;
      end else if (rel) begin
         Valid <= 1'b0;
         Grant <= '0;
         Multi <= 1'b0;
         if (adv) ptr <= Sel + M'(1);
      end
   end

endmodule

// File: tb/tb_rr_priority_encoder.sv
// Directed bench for rr_priority_encoder: vector table plus hand sequences for
// round-robin wrap and asynchronous reset mid-grant.
module tb_rr_priority_encoder;

   localparam int M = 3;
   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] Req = '0;
   logic         Ena = 1'b0;
   logic         Ack = 1'b0;
   logic [M-1:0] Sel;
   logic         Valid;
   logic [N-1:0] Grant;
   logic         Multi;

   int n_cmp = 0;
   int n_bad = 0;

   rr_priority_encoder #(.M(M)) dut (
      .clk(clk), .rst_n(rst_n), .Req(Req), .Ena(Ena), .Ack(Ack),
      .Sel(Sel), .Valid(Valid), .Grant(Grant), .Multi(Multi)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0] req;
      logic         ena;
      logic         ack;
      logic [M-1:0] sel;
      logic         valid;
      logic [N-1:0] grant;
      logic         multi;
   } vec_t;

   localparam int NV = 21;
   vec_t vecs [NV];

   task automatic chk(input string nm, input logic [M-1:0] s, input logic v,
                      input logic [N-1:0] g, input logic mu);
      n_cmp++;
      if ({Sel, Valid, Grant, Multi} !== {s, v, g, mu}) begin
         n_bad++;
         $display("FAIL %s: got sel=%0d valid=%b grant=%h multi=%b, want sel=%0d valid=%b grant=%h multi=%b",
                  nm, Sel, Valid, Grant, Multi, s, v, g, mu);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      Req = '0; Ena = 1'b0; Ack = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      // req, ena, ack -> sel, valid, grant, multi (after the next edge)
      vecs[0]  = '{8'h24, 1, 0, 3'd2, 1, 8'h04, 1}; // ptr0: first of {2,5}
      vecs[1]  = '{8'h24, 1, 1, 3'd2, 0, 8'h00, 0}; // ack -> ptr3
      vecs[2]  = '{8'h24, 1, 0, 3'd5, 1, 8'h20, 1};
      vecs[3]  = '{8'h24, 1, 1, 3'd5, 0, 8'h00, 0}; // ptr6
      vecs[4]  = '{8'h03, 1, 0, 3'd0, 1, 8'h01, 1}; // wrap search 6,7,0
      vecs[5]  = '{8'h03, 1, 1, 3'd0, 0, 8'h00, 0}; // ptr1
      vecs[6]  = '{8'h03, 1, 0, 3'd1, 1, 8'h02, 1};
      vecs[7]  = '{8'h03, 1, 0, 3'd1, 1, 8'h02, 1}; // hold
      vecs[8]  = '{8'h01, 1, 0, 3'd1, 0, 8'h00, 0}; // abort, ptr stays 1
      vecs[9]  = '{8'h03, 1, 0, 3'd1, 1, 8'h02, 1}; // re-search from 1
      vecs[10] = '{8'h03, 1, 1, 3'd1, 0, 8'h00, 0}; // ptr2
      vecs[11] = '{8'h11, 1, 0, 3'd4, 1, 8'h10, 1};
      vecs[12] = '{8'h01, 0, 1, 3'd4, 0, 8'h00, 0}; // ack + dropped req: ptr5
      vecs[13] = '{8'h10, 0, 0, 3'd4, 0, 8'h00, 0}; // ena low: no grant
      vecs[14] = '{8'h10, 0, 1, 3'd4, 0, 8'h00, 0}; // ack in idle ignored
      vecs[15] = '{8'h10, 1, 0, 3'd4, 1, 8'h10, 0}; // single request
      vecs[16] = '{8'h10, 0, 0, 3'd4, 1, 8'h10, 0}; // ena dropped in hold
      vecs[17] = '{8'h10, 0, 0, 3'd4, 1, 8'h10, 0};
      vecs[18] = '{8'h10, 0, 1, 3'd4, 0, 8'h00, 0}; // ptr5
      vecs[19] = '{8'h00, 1, 0, 3'd4, 0, 8'h00, 0}; // no requests
      vecs[20] = '{8'h21, 1, 0, 3'd5, 1, 8'h20, 1}; // from 5: bit5 before 0

      do_reset();
      chk("reset", 3'd0, 1'b0, 8'h00, 1'b0);

      for (int i = 0; i < NV; i++) begin
         Req = vecs[i].req; Ena = vecs[i].ena; Ack = vecs[i].ack;
         tick();
         chk($sformatf("vec%0d", i), vecs[i].sel, vecs[i].valid, vecs[i].grant, vecs[i].multi);
      end

      // fairness with all lines held: 0..7 then wrap to 0, idle between grants
      do_reset();
      Req = 8'hFF; Ena = 1'b1; Ack = 1'b1;
      for (int k = 0; k < 9; k++) begin
         tick();
         chk($sformatf("rr_grant%0d", k), M'(k % N), 1'b1, N'(1) << (k % N), 1'b1);
         tick();
         chk($sformatf("rr_idle%0d", k), M'(k % N), 1'b0, 8'h00, 1'b0);
      end

      // ptr is now 1; take a grant and reset asynchronously while holding it
      Req = 8'h10; Ack = 1'b0;
      tick();
      chk("pre_rst_hold", 3'd4, 1'b1, 8'h10, 1'b0);
      #3 rst_n = 1'b0;
      #1 chk("async_rst", 3'd0, 1'b0, 8'h00, 1'b0);
      #2 rst_n = 1'b1;
      Req = 8'h81; Ena = 1'b1;
      tick();
      chk("post_rst_ptr0", 3'd0, 1'b1, 8'h01, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
